pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the per-channel PWM audio encoder: demodulates one PWM output bit back into an 8-bit PCM sample stream.
- Offers each sample on a valid/ready channel, the same handshake style as the bytebeat generator output ports.
- Used for on-chip loopback (PWM out -> PCM in) and as a bench monitor for the PWM outputs.
- Encoding it inverts: output high for the first N cycles of each 2^WIDTH-cycle period, where N is the sample value. Duty = N/2^WIDTH.

Parameters:
- WIDTH, 8: sample width; the measurement window is 2^WIDTH clk cycles.
- SYNC_STAGES, 2: flip-flop synchronizer depth on pwm_in; minimum 1.
- ALIGN, 1: 1 = window start aligns to the first rising edge after reset; 0 = window free-runs from reset.

Ports:
- clk  in  1  system clock (same clock as the PWM encoder).
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  PWM bit under test; may be asynchronous.
- sample_out  out  WIDTH  demodulated sample.
- sample_vld  out  1  sample_out holds an unconsumed sample.
- sample_rdy  in  1  consumer accepts the sample when sample_vld & sample_rdy.
- locked  out  1  window alignment is established.
- overrun  out  1  sticky flag: a sample was overwritten before it was consumed.

Behaviour:
- Reset (synchronous, active-high), takes effect on the next clk edge:
  - sample_out=0, sample_vld=0, locked=0, overrun=0.
  - Synchronizer flops, window counter and high counter all cleared; FSM goes to SEEK.
  - Reset mid-window discards the partial measurement. No sample is emitted for that window.
- Synchronizer: pwm_s is pwm_in delayed by SYNC_STAGES flops. Edge detect compares pwm_s with its previous value.
- FSM states: SEEK, MEASURE.
  - With ALIGN=0, SEEK lasts exactly one cycle after reset, then MEASURE (locked=1).
  - SEEK (ALIGN=1): the window counter runs as a timeout.
    - Rising edge of pwm_s -> MEASURE, counting that cycle as window cycle 0.
    - Timeout (2^WIDTH cycles with no edge) -> MEASURE starting the next cycle. This handles a constant-0 or constant-1 input.
  - MEASURE: locked=1. The window counter wraps from 2^WIDTH-1 to 0 and the FSM stays in MEASURE forever. There is no re-seek except by reset.
- Measurement:
  - high_cnt (WIDTH+1 bits) adds pwm_s on every window cycle 0..2^WIDTH-1.
  - On the cycle after the last window cycle, sample_out <= min(high_cnt, 2^WIDTH-1) and sample_vld <= 1.
  - high_cnt restarts with the new window cycle 0; no cycles are lost between windows.
  - Saturation: an all-high window (count 256) yields 255.
  - Latency: the sample is visible 1 cycle after the window closes, i.e. SYNC_STAGES+1 cycles after the last encoder-period cycle.
- Handshake:
  - sample_vld, once set, holds with sample_out stable until sample_vld & sample_rdy. It clears on the edge after acceptance.
  - sample_rdy may be high before sample_vld.
  - New sample arrives while sample_vld=1 and not accepted that cycle: sample_out is overwritten, sample_vld stays 1, overrun <= 1.
  - New sample arrives and the old one is accepted in the same cycle: the new sample is loaded, sample_vld stays 1, no overrun.
  - overrun clears only on reset.

Decomposition:
- Shared audio package holds:
  - PCM_WIDTH=8 constant.
  - PWM_PERIOD=2**PCM_WIDTH constant.
  - Sample typedef logic [PCM_WIDTH-1:0].
- One natural sub-module, pwm_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect. Outputs pwm_s and rise.
- Everything else (FSM, counters, output register) lives in pwm_capture.

Test Plan:
- Loopback, ALIGN=1, sample_rdy=1:
  - Stimulus: encoder sample held at 0x80; release reset.
  - Required: locked rises at the first pwm_s rising edge.
  - Required: every sample after the first full window is 0x80; sample_vld pulses one cycle per 256 cycles.
- Extremes:
  - Encoder sample 0x00 (constant 0): locked=1 after the 256-cycle timeout, then samples 0x00.
  - Constant-1 input: samples 0xFF (saturated 256); overrun stays 0.
- Step:
  - Stimulus: encoder sample changes 0x20 -> 0xE0 at a period boundary.
  - Required: exactly one transition in the output, 0x20 to 0xE0. No intermediate value when aligned.
- Backpressure:
  - Stimulus: sample_rdy=0 for 600 cycles with sample 0x40.
  - Required: sample_vld stays 1 and sample_out stays stable within each window.
  - Required: overrun=1 after the second window; on sample_rdy=1 the last sample (0x40) is taken and sample_vld drops the next cycle.
- Simultaneous accept and load:
  - Stimulus: sample_rdy pulsed exactly on the cycle a new sample is loaded.
  - Required: sample_vld remains 1, the new value is presented, overrun stays 0.
- Reset mid-window:
  - Stimulus: reset asserted for 1 cycle at window cycle 100.
  - Required: all outputs 0 on the next edge, FSM back in SEEK.
  - Required: no sample is produced from the partial window; the next sample is correct after relock.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared audio definitions for the PWM capture block: PCM sample width, PWM
// period and the capture FSM state encoding.
package pwm_capture_pkg;

    localparam int PCM_WIDTH  = 8;
    localparam int PWM_PERIOD = 2**PCM_WIDTH;

    typedef logic [PCM_WIDTH-1:0] pcm_sample_t;

    typedef enum logic {
        ST_SEEK    = 1'b0,
        ST_MEASURE = 1'b1
    } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous PWM bit followed by a
// rising-edge detector on the synchronized value.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d;

    // Shift form keeps SYNC_STAGES=1 legal without a special case.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(pwm_in);
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM demodulator: counts high cycles over each 2^WIDTH-cycle window and
// offers the resulting sample on a valid/ready output port.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = PCM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit ALIGN       = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_vld,
    input  logic             sample_rdy,
    output logic             locked,
    output logic             overrun,
    output cap_state_t       fsm_state
);

    cap_state_t       state, state_nxt;
    logic [WIDTH-1:0] win_cnt, win_cnt_nxt;
    logic [WIDTH:0]   high_cnt, high_cnt_nxt;
    logic [WIDTH:0]   high_sum;
    logic [WIDTH-1:0] sample_sat;
    logic             win_last;
    logic             win_done;
    logic             pwm_s;
    logic             rise;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise)
    );

    assign high_sum   = high_cnt + (WIDTH+1)'(pwm_s);
    assign sample_sat = high_sum[WIDTH] ? '1 : high_sum[WIDTH-1:0];
    assign win_last   = (win_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_SEEK;
            win_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            state    <= state_nxt;
            win_cnt  <= win_cnt_nxt;
            high_cnt <= high_cnt_nxt;
        end
    end

    // In SEEK the window counter doubles as the no-edge timeout.
    always_comb begin
        state_nxt    = state;
        win_cnt_nxt  = win_cnt + WIDTH'(1);
        high_cnt_nxt = high_cnt;
        win_done     = 1'b0;
        case (state)
            ST_SEEK: begin
                high_cnt_nxt = '0;
                if (!ALIGN || rise) begin
                    state_nxt    = ST_MEASURE;
                    win_cnt_nxt  = WIDTH'(1);
                    high_cnt_nxt = (WIDTH+1)'(pwm_s);
                end else if (win_last) begin
                    state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (win_last) begin
                    win_done     = 1'b1;
                    high_cnt_nxt = '0;
                end else begin
                    high_cnt_nxt = high_sum;
                end
            end
            default: state_nxt = ST_SEEK;
        endcase
    end

    // Handshake: a sample transfers on any edge where sample_vld & sample_rdy;
    // sample_out is held until then, and a newer window result replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out <= '0;
            sample_vld <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_done) begin
            sample_out <= sample_sat;
            sample_vld <= 1'b1;
            if (sample_vld && !sample_rdy)
                overrun <= 1'b1;
        end else if (sample_vld && sample_rdy) begin
            sample_vld <= 1'b0;
        end
    end

    assign locked    = (state == ST_MEASURE);
    assign fsm_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives a behavioural PWM encoder and
// checks samples, lock timing, handshake and overrun against hand-derived values.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    logic       clk;
    logic       reset;
    logic       pwm_in;
    logic [7:0] sample_out;
    logic       sample_vld;
    logic       sample_rdy;
    logic       locked;
    logic       overrun;
    cap_state_t fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural encoder state
    logic [7:0] enc_cnt    = 8'd0;
    int         enc_val    = 0;
    int         enc_next   = 0;
    bit         enc_run    = 1'b0;
    bit         enc_const1 = 1'b0;

    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    int         vld_cycles = 0;
    int         drop_viol  = 0;

    pwm_capture dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .sample_out (sample_out),
        .sample_vld (sample_vld),
        .sample_rdy (sample_rdy),
        .locked     (locked),
        .overrun    (overrun),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit pend;
        if (sample_vld === 1'b1 && sample_rdy) acc_q.push_back(sample_out);
        if (sample_vld === 1'b1) vld_cycles++;
        pend   = (sample_vld === 1'b1) && !sample_rdy && !reset;
        pwm_in = enc_const1 || (enc_run && (int'(enc_cnt) < enc_val));
        @(posedge clk);
        #1;
        if (pend && sample_vld !== 1'b1) drop_viol++;
        if (enc_run) begin
            enc_cnt++;
            if (enc_cnt == 8'd0) enc_val = enc_next;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int val);
        enc_run = 1'b0;
        reset   = 1'b1;
        tick();
        reset      = 1'b0;
        enc_run    = 1'b1;
        enc_cnt    = 8'd0;
        enc_val    = val;
        enc_next   = val;
        vld_cycles = 0;
        acc_q.delete();
    endtask

    task automatic chk_q(input string tag);
        logic [7:0] got;
        chk({tag, "_count"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
            chk(tag, got, exp_q[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        pwm_in     = 1'b0;
        sample_rdy = 1'b1;

        // reset state, then loopback at 0x80
        do_reset(8'h80);
        chk("rst_sample", sample_out, 8'h00);
        chk("rst_vld", sample_vld, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_state", fsm_state, ST_SEEK);
        ticks(2);
        chk("lb_unlocked", locked, 1'b0);
        tick();
        chk("lb_locked", locked, 1'b1);
        chk("lb_state", fsm_state, ST_MEASURE);
        ticks(255);
        chk("lb_vld1", sample_vld, 1'b1);
        chk("lb_out1", sample_out, 8'h80);
        tick();
        chk("lb_vld_drop", sample_vld, 1'b0);
        ticks(255);
        chk("lb_vld2", sample_vld, 1'b1);
        chk("lb_out2", sample_out, 8'h80);
        ticks(500);
        exp_q = '{8'h80, 8'h80, 8'h80};
        chk_q("lb_samples");
        chk("lb_vld_cycles", vld_cycles, 3);
        chk("lb_overrun", overrun, 1'b0);

        // constant 0: timeout lock
        do_reset(0);
        ticks(255);
        chk("zero_unlocked", locked, 1'b0);
        tick();
        chk("zero_locked", locked, 1'b1);
        ticks(256);
        chk("zero_vld", sample_vld, 1'b1);
        chk("zero_out", sample_out, 8'h00);

        // constant 1: saturated samples
        enc_const1 = 1'b1;
        do_reset(0);
        ticks(2);
        chk("one_unlocked", locked, 1'b0);
        tick();
        chk("one_locked", locked, 1'b1);
        ticks(597);
        exp_q = '{8'hff, 8'hff};
        chk_q("one_samples");
        chk("one_overrun", overrun, 1'b0);
        enc_const1 = 1'b0;

        // step 0x20 -> 0xE0 at a period boundary
        do_reset(8'h20);
        ticks(600);
        enc_next = 8'he0;
        ticks(700);
        exp_q = '{8'h20, 8'h20, 8'h20, 8'he0, 8'he0};
        chk_q("step_samples");

        // backpressure for 600 cycles
        sample_rdy = 1'b0;
        drop_viol  = 0;
        do_reset(8'h40);
        ticks(300);
        chk("bp_vld1", sample_vld, 1'b1);
        chk("bp_out1", sample_out, 8'h40);
        chk("bp_overrun1", overrun, 1'b0);
        ticks(300);
        chk("bp_vld2", sample_vld, 1'b1);
        chk("bp_out2", sample_out, 8'h40);
        chk("bp_overrun2", overrun, 1'b1);
        chk("bp_drops", drop_viol, 0);
        sample_rdy = 1'b1;
        tick();
        chk("bp_vld_drop", sample_vld, 1'b0);
        chk("bp_overrun_sticky", overrun, 1'b1);
        exp_q = '{8'h40};
        chk_q("bp_taken");

        // accept coincides with load
        sample_rdy = 1'b0;
        do_reset(8'h30);
        enc_next = 8'h60;
        ticks(513);
        chk("sim_vld_old", sample_vld, 1'b1);
        chk("sim_out_old", sample_out, 8'h30);
        sample_rdy = 1'b1;
        tick();
        sample_rdy = 1'b0;
        chk("sim_vld_new", sample_vld, 1'b1);
        chk("sim_out_new", sample_out, 8'h60);
        chk("sim_overrun", overrun, 1'b0);
        exp_q = '{8'h30};
        chk_q("sim_taken");
        tick();
        chk("sim_vld_hold", sample_vld, 1'b1);
        sample_rdy = 1'b1;

        // reset at window cycle 100, encoder keeps running
        do_reset(8'h40);
        ticks(358);
        acc_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_sample", sample_out, 8'h00);
        chk("mid_vld", sample_vld, 1'b0);
        chk("mid_locked", locked, 1'b0);
        chk("mid_overrun", overrun, 1'b0);
        chk("mid_state", fsm_state, ST_SEEK);
        ticks(441);
        exp_q = '{8'h40};
        chk_q("mid_relock");
        chk("mid_relocked", locked, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
